// File: rtl/fios_srv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fios_srv_pkg
// Brief    : Shared types and constants for the FIOS operand/result server.
// Revision : 1.0 - initial release
// ============================================================================
package fios_srv_pkg;

    localparam int LIMB_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } srv_state_t;

    localparam logic [1:0] SEL_A      = 2'd0;
    localparam logic [1:0] SEL_B      = 2'd1;
    localparam logic [1:0] SEL_P      = 2'd2;
    localparam logic [1:0] SEL_PPRIME = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fios_operand_server_limb_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fios_limb_ptr
// Brief    : Wrapping modulo-S limb pointer with clear and advance inputs.
//            o_ptr_nx exposes the value the pointer takes at the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module fios_limb_ptr #(
    parameter int S      = 8,
    parameter int ADDR_W = $clog2(S)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_ptr,
    output logic [ADDR_W-1:0] o_ptr_nx
);

    logic [ADDR_W-1:0] r_ptr;

    always_comb begin
        o_ptr_nx = r_ptr;
        if (i_clr) begin
            o_ptr_nx = '0;
        end else if (i_adv) begin
            o_ptr_nx = (r_ptr == ADDR_W'(S - 1)) ? '0 : r_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= o_ptr_nx;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fios_operand_server.sv
`default_nettype none
// ============================================================================
// Module   : fios_operand_server
// Brief    : Host-facing operand/result server for the FIOS cascade multiplier.
//            Optional macro FIOS_SRV_RES_CNT_CHECK_EN flags a short result count.
// Revision : 1.0 - initial release
// ============================================================================
module fios_operand_server
    import fios_srv_pkg::*;
#(
    parameter int S     = 8,
    parameter int PE_NB = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      wr_en_i,
    input  logic [1:0]                wr_sel_i,
    input  logic [$clog2(S)-1:0]      wr_addr_i,
    input  logic [LIMB_W-1:0]         wr_data_i,
    input  logic                      start_i,
    input  logic [$clog2(S)-1:0]      rd_addr_i,
    output logic [LIMB_W-1:0]         rd_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      fios_start_o,
    output logic [LIMB_W-1:0]         fios_p_prime_0_o,
    output logic [PE_NB*LIMB_W-1:0]   fios_a_o,
    output logic [LIMB_W-1:0]         fios_b_o,
    output logic [LIMB_W-1:0]         fios_p_o,
    input  logic                      fios_a_shift_i,
    input  logic                      fios_b_fetch_i,
    input  logic                      fios_p_fetch_i,
    input  logic                      fios_RES_push_i,
    input  logic [LIMB_W-1:0]         fios_RES_i,
    input  logic                      fios_done_i
);

    localparam int ADDR_W = $clog2(S);
    localparam int RES_W  = $clog2(S + 1);
    localparam int A_MAX  = ((S + PE_NB - 1) / PE_NB) * PE_NB;
    localparam int AB_W   = $clog2(A_MAX + PE_NB);

    srv_state_t r_state;
    srv_state_t w_state_nx;

    logic [LIMB_W-1:0] r_a_mem   [S];
    logic [LIMB_W-1:0] r_b_mem   [S];
    logic [LIMB_W-1:0] r_p_mem   [S];
    logic [LIMB_W-1:0] r_res_mem [S];
    logic [LIMB_W-1:0] w_a_mem_nx [S];

    logic [AB_W-1:0]         r_a_base;
    logic [AB_W-1:0]         w_a_base_nx;
    logic [RES_W-1:0]        r_res_ptr;
    logic [ADDR_W-1:0]       w_b_ptr;
    logic [ADDR_W-1:0]       w_b_ptr_nx;
    logic [ADDR_W-1:0]       w_p_ptr;
    logic [ADDR_W-1:0]       w_p_ptr_nx;
    logic [PE_NB*LIMB_W-1:0] w_a_win;
    logic [LIMB_W-1:0]       w_b_srv;
    logic [LIMB_W-1:0]       w_p_srv;

    logic                    r_err;
    logic                    r_start;
    logic [LIMB_W-1:0]       r_pprime;
    logic [PE_NB*LIMB_W-1:0] r_fios_a;
    logic [LIMB_W-1:0]       r_fios_b;
    logic [LIMB_W-1:0]       r_fios_p;
    logic [LIMB_W-1:0]       r_rd;

    logic w_in_run;
    logic w_start_acc;
    logic w_wr_acc;
    logic w_wr_a;
    logic w_wr_b;
    logic w_wr_p;
    logic w_wr_pp;
    logic w_push_ok;
    logic w_push_ovf;
    logic w_cnt_err;
    logic w_err_set;

    assign w_in_run    = (r_state == RUN);
    assign w_start_acc = start_i && !w_in_run;
    assign w_wr_acc    = wr_en_i && !w_in_run;
    assign w_wr_a      = w_wr_acc && (wr_sel_i == SEL_A);
    assign w_wr_b      = w_wr_acc && (wr_sel_i == SEL_B);
    assign w_wr_p      = w_wr_acc && (wr_sel_i == SEL_P);
    assign w_wr_pp     = w_wr_acc && (wr_sel_i == SEL_PPRIME);
    assign w_push_ok   = w_in_run && fios_RES_push_i && (r_res_ptr != RES_W'(S));
    assign w_push_ovf  = w_in_run && fios_RES_push_i && (r_res_ptr == RES_W'(S));

`ifdef FIOS_SRV_RES_CNT_CHECK_EN
    logic [RES_W-1:0] w_res_cnt_nx;
    assign w_res_cnt_nx = r_res_ptr + {{(RES_W-1){1'b0}}, w_push_ok};
    assign w_cnt_err    = w_in_run && fios_done_i && (w_res_cnt_nx != RES_W'(S));
`else
    assign w_cnt_err    = 1'b0;
`endif

    assign w_err_set = (w_in_run && (wr_en_i || start_i)) || w_push_ovf || w_cnt_err;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE, DONE: if (start_i)     w_state_nx = RUN;
            RUN:        if (fios_done_i) w_state_nx = DONE;
            default:                     w_state_nx = IDLE;
        endcase
    end

    // Limb stores and result buffer deliberately keep their contents across reset.
    always_ff @(posedge clock_i) begin
        if (w_wr_a)    r_a_mem[wr_addr_i] <= wr_data_i;
        if (w_wr_b)    r_b_mem[wr_addr_i] <= wr_data_i;
        if (w_wr_p)    r_p_mem[wr_addr_i] <= wr_data_i;
        if (w_push_ok) r_res_mem[r_res_ptr[ADDR_W-1:0]] <= fios_RES_i;
    end

    fios_limb_ptr #(.S(S), .ADDR_W(ADDR_W)) u_b_ptr (
        .clk      (clock_i),
        .rst      (reset_i),
        .i_clr    (w_start_acc),
        .i_adv    (w_in_run && fios_b_fetch_i),
        .o_ptr    (w_b_ptr),
        .o_ptr_nx (w_b_ptr_nx)
    );

    fios_limb_ptr #(.S(S), .ADDR_W(ADDR_W)) u_p_ptr (
        .clk      (clock_i),
        .rst      (reset_i),
        .i_clr    (w_start_acc),
        .i_adv    (w_in_run && fios_p_fetch_i),
        .o_ptr    (w_p_ptr),
        .o_ptr_nx (w_p_ptr_nx)
    );

    // Served limbs are built from next-cycle pointers and store contents, so a
    // write coinciding with start shows up together with the start pulse.
    assign w_b_srv = (w_wr_b && (wr_addr_i == w_b_ptr_nx)) ? wr_data_i : r_b_mem[w_b_ptr_nx];
    assign w_p_srv = (w_wr_p && (wr_addr_i == w_p_ptr_nx)) ? wr_data_i : r_p_mem[w_p_ptr_nx];

    always_comb begin
        w_a_base_nx = r_a_base;
        if (w_start_acc) begin
            w_a_base_nx = '0;
        end else if (w_in_run && fios_a_shift_i && (r_a_base != AB_W'(A_MAX))) begin
            w_a_base_nx = r_a_base + AB_W'(PE_NB);
        end
    end

    always_comb begin
        for (int i = 0; i < S; i++) begin
            w_a_mem_nx[i] = (w_wr_a && (wr_addr_i == ADDR_W'(i))) ? wr_data_i : r_a_mem[i];
        end
    end

    for (genvar k = 0; k < PE_NB; k++) begin : g_win
        logic [AB_W-1:0] w_idx;
        assign w_idx = w_a_base_nx + AB_W'(k);
        assign w_a_win[k*LIMB_W +: LIMB_W] =
            (w_idx < AB_W'(S)) ? w_a_mem_nx[w_idx[ADDR_W-1:0]] : '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_a_base  <= '0;
            r_res_ptr <= '0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_pprime  <= '0;
            r_fios_a  <= '0;
            r_fios_b  <= '0;
            r_fios_p  <= '0;
            r_rd      <= '0;
        end else begin
            r_a_base <= w_a_base_nx;
            r_start  <= w_start_acc;
            r_fios_a <= w_a_win;
            r_fios_b <= w_b_srv;
            r_fios_p <= w_p_srv;
            r_rd     <= r_res_mem[rd_addr_i];
            if (w_wr_pp) begin
                r_pprime <= wr_data_i;
            end
            if (w_start_acc) begin
                r_res_ptr <= '0;
            end else if (w_push_ok) begin
                r_res_ptr <= r_res_ptr + RES_W'(1);
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_data_o        = r_rd;
    assign busy_o           = (r_state == RUN);
    assign done_o           = (r_state == DONE);
    assign err_o            = r_err;
    assign fios_start_o     = r_start;
    assign fios_p_prime_0_o = r_pprime;
    assign fios_a_o         = r_fios_a;
    assign fios_b_o         = r_fios_b;
    assign fios_p_o         = r_fios_p;

endmodule
`default_nettype wire

// File: doc/fios_operand_server.md
Name: fios_operand_server

Overview:
- Host-facing operand/result server for the FIOS cascade multiplier; the responder to its a_shift/b_fetch/p_fetch/RES_push/done strobes.
- Holds the a, b and p limb stores and the p' register, and issues the start pulse.
- Serves limbs on the multiplier's fetch strobes.
- Captures result limbs into a readable result buffer and reports completion to the host.

Parameters:
- s, 8: number of 17-bit limbs per operand.
- PE_NB, 8: PE count; width of the a window in limbs.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- wr_en_i  in  1  host limb write strobe.
- wr_sel_i  in  2  target store: 0=a, 1=b, 2=p, 3=p_prime_0 (wr_addr_i ignored).
- wr_addr_i  in  $clog2(s)  limb index.
- wr_data_i  in  17  limb data.
- start_i  in  1  host start request.
- rd_addr_i  in  $clog2(s)  result limb index.
- rd_data_o  out  17  result limb, registered, 1-cycle read latency.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- err_o  out  1  sticky protocol error.
- fios_start_o  out  1  one-cycle start pulse to multiplier.
- fios_p_prime_0_o  out  17  p' register.
- fios_a_o  out  PE_NB*17  current a window, limb k at bits [17k+16:17k].
- fios_b_o  out  17  current b limb.
- fios_p_o  out  17  current p limb.
- fios_a_shift_i  in  1  advance a window.
- fios_b_fetch_i  in  1  advance b pointer.
- fios_p_fetch_i  in  1  advance p pointer.
- fios_RES_push_i  in  1  result limb valid.
- fios_RES_i  in  17  result limb.
- fios_done_i  in  1  multiplication complete.

Behaviour:
- Clock and reset: one clock, clock_i. reset_i is asynchronous active-high.
- Reset values:
  - All outputs 0; state IDLE; all pointers 0.
  - p' register is 0.
  - Limb stores and the result buffer are not reset; their contents are preserved across reset.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - Host writes land in the selected store.
    - start_i moves to RUN. On that transition: assert fios_start_o for exactly one cycle, clear a_base/b_ptr/p_ptr/res_ptr and clear err_o.
  - RUN:
    - Service strobes as described below.
    - fios_done_i moves to DONE.
  - DONE:
    - Host writes are allowed.
    - start_i behaves as in IDLE (restart).
    - rd_data_o is meaningful in every state; in DONE the result buffer is guaranteed complete.
- b/p serving:
  - fios_b_o is registered from b_mem[b_ptr].
  - On entry to RUN, fios_b_o = b[0] from the cycle fios_start_o is high.
  - fios_b_fetch_i in cycle t: b_ptr <= (b_ptr == s-1) ? 0 : b_ptr+1, and fios_b_o shows the new limb at t+1. The pointer wraps, since every FIOS iteration re-reads all s limbs.
  - The p pointer is independent and behaves identically.
  - Strobes outside RUN are ignored.
- a window:
  - fios_a_o limb k = a[a_base+k] when a_base+k < s, else 0.
  - fios_a_shift_i: a_base += PE_NB, saturating so that a_base never exceeds the first multiple of PE_NB that is >= s.
  - The window is registered; it updates 1 cycle after the strobe.
- Result capture:
  - fios_RES_push_i in RUN: res_mem[res_ptr] <= fios_RES_i, then res_ptr++.
  - A push with res_ptr == s is dropped and sets err_o.
- Simultaneous events:
  - fios_RES_push_i and fios_done_i in the same cycle: the push is captured, then the FSM enters DONE.
  - fios_b_fetch_i and fios_p_fetch_i together: both pointers advance.
  - start_i and wr_en_i together in IDLE: the write is performed, and start is taken in the same cycle; a b/p write at index 0 is visible on fios_b_o/fios_p_o one cycle later.
- Protocol errors:
  - wr_en_i or start_i during RUN is ignored and sets err_o.
  - err_o holds until the next accepted start or reset.
- Reset mid-RUN: returns to IDLE immediately, with no fios_start_o and no done_o.

Optional Feature:
- Macro FIOS_SRV_RES_CNT_CHECK_EN.
- Defined: on fios_done_i, if res_ptr (after any same-cycle push) != s, set err_o.
- Undefined: no count check; err_o reflects only the overflow and write/start-during-RUN errors.

Decomposition:
- Shared package fios_srv_pkg:
  - state enum {IDLE, RUN, DONE};
  - wr_sel encoding constants SEL_A/SEL_B/SEL_P/SEL_PPRIME;
  - LIMB_W = 17.
- One sub-module, fios_limb_ptr: a wrapping modulo-s pointer with clear and advance inputs, instantiated for b and p.

Test Plan:
- Load a=b=p=limbs 1..8, p'=0x1ABCD, pulse start -> fios_start_o high for 1 cycle, busy_o=1, fios_b_o=1, fios_p_o=1, fios_p_prime_0_o=0x1ABCD.
- 8 b_fetch pulses -> fios_b_o goes 2,3,...,8 and then wraps to 1; p stays 1 with no p_fetch.
- s=8, PE_NB=3: two a_shift pulses -> window limbs (1,2,3) -> (4,5,6) -> (7,8,0).
- Push results 0x10..0x17 with done on the last push -> done_o=1, rd_addr_i=7 gives 0x17 next cycle, err_o=0.
- Ninth push, or wr_en_i during RUN -> err_o=1 and stores unchanged; with FIOS_SRV_RES_CNT_CHECK_EN, done after 7 pushes -> err_o=1.
- Assert reset_i mid-RUN -> outputs 0 asynchronously and state IDLE; a following start serves b[0] correctly.
